// File: rtl/elastic_async_operator.sv
// Dataflow operator node: per-input FIFOs feed a reduction op whose result forks to independently acked outputs.
// Fires one edge after all heads are visible, ack_r one edge after fire; req_l drops once a FIFO has no spare slot.

module elastic_async_operator #(
   parameter int    DATA_WIDTH = 32,
   parameter int    INPUTS     = 2,
   parameter int    OUTPUTS    = 1,
   parameter int    DEPTH      = 4,
   parameter string OP         = "add",
   parameter int    IMMEDIATE  = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic [INPUTS-1:0]            req_l,
   input  logic [INPUTS-1:0]            ack_l,
   input  logic [DATA_WIDTH*INPUTS-1:0] din,
   input  logic [OUTPUTS-1:0]           req_r,
   output logic [OUTPUTS-1:0]           ack_r,
   output logic [DATA_WIDTH-1:0]        dout,
   output logic [31:0]                  fire_count,
   output logic                         overflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW = AW + 1;
   localparam int CW = OW + 1;

   localparam int OP_SEL = (OP == "reg")  ? 0 :
                           (OP == "addi") ? 1 :
                           (OP == "subi") ? 2 :
                           (OP == "muli") ? 3 :
                           (OP == "add")  ? 4 :
                           (OP == "sub")  ? 5 :
                           (OP == "mul")  ? 6 : -1;
   localparam bit IMM_OP   = (OP_SEL >= 0) && (OP_SEL <= 3);
   localparam bit OP_OK    = (OP_SEL >= 0) && (IMM_OP ? (INPUTS == 1) : (INPUTS >= 2));
   localparam bit SIZE_OK  = (INPUTS >= 1) && (INPUTS <= 4) && (OUTPUTS >= 1) && (OUTPUTS <= 8) &&
                             (DEPTH >= 2) && (DEPTH <= 16) && ((DEPTH & (DEPTH - 1)) == 0);
   localparam logic [DATA_WIDTH-1:0] IMM = DATA_WIDTH'(IMMEDIATE);

   if (!(OP_OK && SIZE_OK)) begin : g_illegal
      $error("elastic_async_operator: illegal OP/INPUTS/OUTPUTS/DEPTH combination");
   end

   logic [DATA_WIDTH-1:0] head [INPUTS];
   logic [INPUTS-1:0]     full;
   logic [INPUTS-1:0]     empty;
   logic [INPUTS-1:0]     push;
   logic [INPUTS-1:0]     req_nx;
   logic [OUTPUTS-1:0]    out_pend;
   logic [DATA_WIDTH-1:0] result;
   logic                  fire;

   assign fire = (&(~empty)) & ~(|out_pend);

   for (genvar i = 0; i < INPUTS; i++) begin : g_ch
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [AW-1:0]         wr_ptr;
      logic [AW-1:0]         rd_ptr;
      logic [OW-1:0]         cnt;

      // A full FIFO still accepts a push when the same edge pops it.
      assign push[i]  = ack_l[i] & (~full[i] | fire);
      assign full[i]  = (cnt == OW'(DEPTH));
      assign empty[i] = (cnt == '0);
      assign head[i]  = mem[rd_ptr];

      // Keep one slot free for an ack that may already be on its way.
      assign req_nx[i] = (CW'(cnt) + CW'(push[i])) <= (CW'(DEPTH - 2) + CW'(fire));

      always_ff @(posedge clk) begin
         if (push[i]) mem[wr_ptr] <= din[DATA_WIDTH*i +: DATA_WIDTH];
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (push[i]) wr_ptr <= wr_ptr + AW'(1);
            if (fire)    rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + OW'(push[i]) - OW'(fire);
         end
      end
   end

   always_comb begin
      result = head[0];
      case (OP_SEL)
         1: result = head[0] + IMM;
         2: result = head[0] - IMM;
         3: result = head[0] * IMM;
         4: for (int i = 1; i < INPUTS; i++) result = result + head[i];
         5: for (int i = 1; i < INPUTS; i++) result = result - head[i];
         6: for (int i = 1; i < INPUTS; i++) result = result * head[i];
         default: result = head[0];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_l      <= '0;
         ack_r      <= '0;
         out_pend   <= '0;
         dout       <= '0;
         fire_count <= '0;
         overflow   <= 1'b0;
      end else begin
         req_l <= req_nx;
         if (|(ack_l & full & ~{INPUTS{fire}})) overflow <= 1'b1;
         if (fire) begin
            dout       <= result;
            fire_count <= fire_count + 32'd1;
         end
         for (int j = 0; j < OUTPUTS; j++) begin
            if (out_pend[j] && req_r[j] && !ack_r[j]) begin
               ack_r[j]    <= 1'b1;
               out_pend[j] <= 1'b0;
            end else begin
               ack_r[j] <= 1'b0;
            end
         end
         // Fire only happens with nothing pending, so this never collides with a clear above.
         if (fire) out_pend <= '1;
      end
   end

endmodule

// File: tb/tb_elastic_async_operator.sv
// Bench for elastic_async_operator: add/2-in, sub/3-in with a 3-way fork, muli/1-in.
module tb_elastic_async_operator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // dut0: add, 2 inputs, 1 output
   logic [1:0]  req_l0, ack_l0;
   logic [63:0] din0;
   logic [0:0]  req_r0, ack_r0;
   logic [31:0] dout0, fc0;
   logic        ov0;
   // dut1: sub, 3 inputs, 3 outputs
   logic [2:0]  req_l1, ack_l1;
   logic [95:0] din1;
   logic [2:0]  req_r1, ack_r1;
   logic [31:0] dout1, fc1;
   logic        ov1;
   // dut2: muli, 1 input, 1 output
   logic [0:0]  req_l2, ack_l2;
   logic [31:0] din2;
   logic [0:0]  req_r2, ack_r2;
   logic [31:0] dout2, fc2;
   logic        ov2;

   elastic_async_operator #(.DATA_WIDTH(32), .INPUTS(2), .OUTPUTS(1), .DEPTH(4), .OP("add"), .IMMEDIATE(0)) u_add (
      .clk(clk), .rst(rst), .req_l(req_l0), .ack_l(ack_l0), .din(din0),
      .req_r(req_r0), .ack_r(ack_r0), .dout(dout0), .fire_count(fc0), .overflow(ov0));

   elastic_async_operator #(.DATA_WIDTH(32), .INPUTS(3), .OUTPUTS(3), .DEPTH(4), .OP("sub"), .IMMEDIATE(0)) u_sub (
      .clk(clk), .rst(rst), .req_l(req_l1), .ack_l(ack_l1), .din(din1),
      .req_r(req_r1), .ack_r(ack_r1), .dout(dout1), .fire_count(fc1), .overflow(ov1));

   elastic_async_operator #(.DATA_WIDTH(32), .INPUTS(1), .OUTPUTS(1), .DEPTH(4), .OP("muli"), .IMMEDIATE(3)) u_muli (
      .clk(clk), .rst(rst), .req_l(req_l2), .ack_l(ack_l2), .din(din2),
      .req_r(req_r2), .ack_r(ack_r2), .dout(dout2), .fire_count(fc2), .overflow(ov2));

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [7];

   logic [31:0] chq0 [$];
   logic [31:0] chq1 [$];
   logic [31:0] exp0 [$];
   logic [31:0] exp1 [$];
   logic [31:0] exp2 [$];
   int fires_exp0 = 0;
   int base0 = 0;
   int idx1 [3] = '{0, 0, 0};
   int acks1 [3] = '{0, 0, 0};
   int pushes0 [2] = '{0, 0};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Pair the k-th accepted value of each channel into one expected sum.
   function automatic void pair_up();
      while (chq0.size() > 0 && chq1.size() > 0) begin
         exp0.push_back(chq0.pop_front() + chq1.pop_front());
         fires_exp0++;
      end
   endfunction

   // Scoreboards: every ack pulse must carry the next expected result.
   always @(negedge clk) begin
      if (!rst && ack_r0[0]) begin
         if (exp0.size() == 0) begin
            tests++; fails++;
            $display("FAIL dut0_spurious_ack: ack_r pulsed with dout=%0h, want no ack", dout0);
         end else begin
            check("dut0_dout", dout0, exp0.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         for (int j = 0; j < 3; j++) begin
            if (ack_r1[j]) begin
               acks1[j]++;
               if (idx1[j] < exp1.size()) begin
                  check($sformatf("dut1_dout_out%0d", j), dout1, exp1[idx1[j]]);
               end else begin
                  tests++; fails++;
                  $display("FAIL dut1_spurious_ack: out%0d pulsed with dout=%0h, want no ack", j, dout1);
               end
               idx1[j]++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ack_r2[0]) begin
         if (exp2.size() == 0) begin
            tests++; fails++;
            $display("FAIL dut2_spurious_ack: ack_r pulsed with dout=%0h, want no ack", dout2);
         end else begin
            check("dut2_dout", dout2, exp2.pop_front());
         end
      end
   end

   task automatic push0(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                        input bit wait_req, input bit rec);
      int n = 0;
      while (wait_req && ((req_l0 & m) != m) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         tests++; fails++;
         $display("FAIL push0_req_timeout: req_l=%b, want %b", req_l0, m);
      end
      ack_l0 = m;
      din0   = {b, a};
      if (rec && m[0]) chq0.push_back(a);
      if (rec && m[1]) chq1.push_back(b);
      pair_up();
      @(negedge clk);
      ack_l0 = '0;
      @(negedge clk);
   endtask

   task automatic push1(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] exp);
      int n = 0;
      while (req_l1 != 3'b111 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         tests++; fails++;
         $display("FAIL push1_req_timeout: req_l=%b, want 111", req_l1);
      end
      exp1.push_back(exp);
      ack_l1 = 3'b111;
      din1   = {c, b, a};
      @(negedge clk);
      ack_l1 = '0;
      @(negedge clk);
   endtask

   task automatic push2(input logic [31:0] a, input logic [31:0] exp);
      int n = 0;
      while (!req_l2[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         tests++; fails++;
         $display("FAIL push2_req_timeout: req_l=%b, want 1", req_l2);
      end
      exp2.push_back(exp);
      ack_l2 = 1'b1;
      din2   = a;
      @(negedge clk);
      ack_l2 = 1'b0;
      @(negedge clk);
   endtask

   task automatic drain0(input string name);
      int n = 0;
      while (exp0.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check(name, exp0.size(), 0);
   endtask

   task automatic buffer_run();
      logic [1:0] m;
      req_r0 = 1'b0;
      base0 = fires_exp0;
      pushes0 = '{0, 0};
      for (int c = 0; c < 40; c++) begin
         m = req_l0 & ~ack_l0;
         ack_l0 = m;
         din0 = {32'(2000 + c), 32'(1000 + c)};
         if (m[0]) begin chq0.push_back(32'(1000 + c)); pushes0[0]++; end
         if (m[1]) begin chq1.push_back(32'(2000 + c)); pushes0[1]++; end
         pair_up();
         @(negedge clk);
      end
      ack_l0 = '0;
      @(negedge clk);
      check("buf_fire_count", fc0, 32'(base0 + 1));
      check("buf_ch0_accepted", pushes0[0], 4);
      check("buf_ch1_accepted", pushes0[1], 4);
      check("buf_req_l_low", req_l0, 2'b00);
      check("buf_overflow", ov0, 1'b0);
      req_r0 = 1'b1;
      drain0("buf_drain");
      check("buf_fire_count_after", fc0, 32'(fires_exp0));
      check("buf_overflow_after", ov0, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      ack_l0 = '0; din0 = '0; req_r0 = 1'b1;
      ack_l1 = '0; din1 = '0; req_r1 = 3'b000;
      ack_l2 = '0; din2 = '0; req_r2 = 1'b0;

      tbl[0] = '{32'd1,          32'd10,         32'd11};
      tbl[1] = '{32'd2,          32'd20,         32'd22};
      tbl[2] = '{32'd3,          32'd30,         32'd33};
      tbl[3] = '{32'hFFFF_FFFF,  32'd2,          32'd1};
      tbl[4] = '{32'd0,          32'd0,          32'd0};
      tbl[5] = '{32'h8000_0000,  32'h8000_0000,  32'd0};
      tbl[6] = '{32'h1234_5678,  32'd1,          32'h1234_5679};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_l", req_l0, 2'b00);
      check("rst_ack_r", ack_r0, 1'b0);
      check("rst_dout", dout0, 32'd0);
      check("rst_fire_count", fc0, 32'd0);
      check("rst_overflow", ov0, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_req_l", req_l0, 2'b11);

      // Table-driven add vectors
      for (int k = 0; k < 7; k++) begin
         exp0.push_back(tbl[k].exp);
         fires_exp0++;
         push0(2'b11, tbl[k].a, tbl[k].b, 1'b1, 1'b0);
         if (k == 2) begin
            drain0("tbl_drain3");
            check("tbl_fire_count3", fc0, 32'd3);
         end
      end
      drain0("tbl_drain");
      check("tbl_fire_count", fc0, 32'(fires_exp0));

      // Buffering with downstream stalled
      buffer_run();

      // Overflow on a full FIFO; queued data must survive
      req_r0 = 1'b0;
      for (int k = 0; k < 4; k++) push0(2'b01, 32'(11 + k), 32'd0, 1'b0, 1'b1);
      push0(2'b01, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
      check("ovf_set", ov0, 1'b1);
      check("ovf_no_fire", fc0, 32'(fires_exp0));
      for (int k = 0; k < 4; k++) push0(2'b10, 32'd0, 32'(100 * (k + 1)), 1'b1, 1'b1);
      req_r0 = 1'b1;
      drain0("ovf_drain");
      check("ovf_sticky", ov0, 1'b1);

      // Fork skew: out2 held back
      req_r1 = 3'b011;
      push1(32'd100, 32'd30, 32'd5, 32'd65);
      push1(32'd50, 32'd20, 32'd10, 32'd20);
      repeat (10) @(negedge clk);
      check("fork_ack0_once", acks1[0], 1);
      check("fork_ack1_once", acks1[1], 1);
      check("fork_ack2_none", acks1[2], 0);
      check("fork_single_fire", fc1, 32'd1);
      check("fork_dout_held", dout1, 32'd65);
      req_r1 = 3'b111;
      begin
         int n = 0;
         while ((acks1[0] < 2 || acks1[1] < 2 || acks1[2] < 2) && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      repeat (3) @(negedge clk);
      check("fork_ack0_total", acks1[0], 2);
      check("fork_ack1_total", acks1[1], 2);
      check("fork_ack2_total", acks1[2], 2);
      check("fork_fire_count", fc1, 32'd2);
      check("fork_dout_second", dout1, 32'd20);

      // Immediate multiply
      req_r2 = 1'b1;
      push2(32'd7, 32'd21);
      push2(32'hFFFF_FFFF, 32'hFFFF_FFFD);
      push2(32'd0, 32'd0);
      begin
         int n = 0;
         while (exp2.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      check("muli_drain", exp2.size(), 0);
      check("muli_fire_count", fc2, 32'd3);

      // Asynchronous reset in the middle of traffic
      req_r0 = 1'b0;
      for (int k = 0; k < 4; k++) push0(2'b11, 32'(k + 1), 32'(10 * (k + 1)), 1'b1, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("midrst_req_l", req_l0, 2'b00);
      check("midrst_ack_r", ack_r0, 1'b0);
      check("midrst_dout", dout0, 32'd0);
      check("midrst_fire_count", fc0, 32'd0);
      check("midrst_overflow", ov0, 1'b0);
      chq0.delete();
      chq1.delete();
      exp0.delete();
      fires_exp0 = 0;
      @(negedge clk);
      rst = 1'b0;
      req_r0 = 1'b1;
      repeat (6) @(negedge clk);
      check("midrst_no_stale_fire", fc0, 32'd0);
      push0(2'b11, 32'd5, 32'd6, 1'b1, 1'b1);
      drain0("midrst_drain");
      check("midrst_fire_count_after", fc0, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
